// File: rtl/gp_arb_if.sv
// Core-side register bus between gp_arb and the register core.
// The arbiter drives address/data/strobe; the core returns registered
// read data and an error flag one cycle after the access.
interface gp_arb_if #(
   parameter int AW = 8,
   parameter int DW = 32
) ();
   logic [AW-1:0] oWADR;
   logic          oWR;
   logic [DW-1:0] oWDAT;
   logic [AW-1:0] oRADR;
   logic [DW-1:0] iRDAT;
   logic          iERR;

   modport master (
      output oWADR, oWR, oWDAT, oRADR,
      input  iRDAT, iERR
   );

   modport slave (
      input  oWADR, oWR, oWDAT, oRADR,
      output iRDAT, iERR
   );
endinterface

// File: rtl/gp_arb.sv
// Two-requester arbiter in front of a single register core.
// One transaction per grant: IDLE -> ISSUE -> RESP, ACK pulse back in IDLE.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting; grants the winning eligible request
// ISSUE | latched command driven onto the core bus for one cycle
// RESP  | core read data / error valid; captured for the winner
module gp_arb #(
   parameter int RR = 1,
   parameter int AW = 8,
   parameter int DW = 32
) (
   input  logic          iCLK,
   input  logic          iRSTN,
   input  logic          iREQ0,
   input  logic          iREQ1,
   input  logic          iWE0,
   input  logic          iWE1,
   input  logic [AW-1:0] iADR0,
   input  logic [AW-1:0] iADR1,
   input  logic [DW-1:0] iWDAT0,
   input  logic [DW-1:0] iWDAT1,
   output logic          oACK0,
   output logic          oACK1,
   output logic [DW-1:0] oRDAT0,
   output logic [DW-1:0] oRDAT1,
   output logic          oERR0,
   output logic          oERR1,
   output logic          oBUSY,
   gp_arb_if.master      core
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } stateT;

   stateT         state;
   stateT         stateNxt;
   logic          grant;
   logic          winner;
   logic          lastGnt;
   logic          cmdIdx;
   logic          cmdWe;
   logic [AW-1:0] cmdAdr;
   logic [DW-1:0] cmdWdat;
   logic          elig0;
   logic          elig1;

   // A requester still high during its own ACK cycle is not re-granted.
   assign elig0 = iREQ0 & ~oACK0;
   assign elig1 = iREQ1 & ~oACK1;

   // Winner select: tie goes to the requester not granted last (RR) or to 0.
   always_comb begin
      winner = 1'b0;
      if (elig0 && elig1) begin
         winner = (RR != 0) ? ~lastGnt : 1'b0;
      end else if (elig1) begin
         winner = 1'b1;
      end
   end

   // Next-state logic; grant marks the IDLE->ISSUE transition.
   always_comb begin
      stateNxt = state;
      grant    = 1'b0;
      case (state)
         IDLE: begin
            if (elig0 || elig1) begin
               stateNxt = ISSUE;
               grant    = 1'b1;
            end
         end
         ISSUE:   stateNxt = RESP;
         RESP:    stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   // State register plus command latch and last-grant pointer, loaded on grant.
   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state   <= IDLE;
         lastGnt <= 1'b1;
         cmdIdx  <= 1'b0;
         cmdWe   <= 1'b0;
         cmdAdr  <= '0;
         cmdWdat <= '0;
      end else begin
         state <= stateNxt;
         if (grant) begin
            lastGnt <= winner;
            cmdIdx  <= winner;
            cmdWe   <= winner ? iWE1 : iWE0;
            cmdAdr  <= winner ? iADR1 : iADR0;
            cmdWdat <= winner ? iWDAT1 : iWDAT0;
         end
      end
   end

   // Response capture for the latched winner; the other side holds its value.
   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         oACK0  <= 1'b0;
         oACK1  <= 1'b0;
         oRDAT0 <= '0;
         oRDAT1 <= '0;
         oERR0  <= 1'b0;
         oERR1  <= 1'b0;
      end else begin
         oACK0 <= 1'b0;
         oACK1 <= 1'b0;
         if (state == RESP) begin
            if (cmdIdx == 1'b0) begin
               oACK0  <= 1'b1;
               oRDAT0 <= core.iRDAT;
               oERR0  <= core.iERR;
            end else begin
               oACK1  <= 1'b1;
               oRDAT1 <= core.iRDAT;
               oERR1  <= core.iERR;
            end
         end
      end
   end

   // Core bus carries the latched command only during ISSUE, zero otherwise.
   assign core.oWR   = (state == ISSUE) & cmdWe;
   assign core.oWADR = (state == ISSUE) ? cmdAdr : '0;
   assign core.oRADR = (state == ISSUE) ? cmdAdr : '0;
   assign core.oWDAT = (state == ISSUE) ? cmdWdat : '0;
   assign oBUSY      = (state != IDLE);

endmodule
